// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 datapath: shift operation encoding used by
// the shift unit and the ALU decoder.
package jedro_1_defines;

  typedef enum logic [2:0] {
    ShiftSll = 3'd0,
    ShiftSrl = 3'd1,
    ShiftSra = 3'd2,
    ShiftRol = 3'd3,
    ShiftRor = 3'd4
  } shift_op_e;

endpackage

// File: rtl/jedro_1_shift_step.sv
// One combinational shift step of 0..MAX_STEP bits; the multi-cycle unit chains
// these steps to reach the full shift amount.
module jedro_1_shift_step
  import jedro_1_defines::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_STEP   = 4,
  localparam int unsigned AmtWidth  = $clog2(MAX_STEP + 1)
) (
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [AmtWidth-1:0]   amt_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [2*DATA_WIDTH-1:0] rol_wide;
  logic [2*DATA_WIDTH-1:0] ror_wide;
  logic [DATA_WIDTH-1:0]   sra_data;

  // Rotations shift a doubled copy so bits pushed out of one half land in the other.
  assign rol_wide = {data_i, data_i} << amt_i;
  assign ror_wide = {data_i, data_i} >> amt_i;
  assign sra_data = $unsigned($signed(data_i) >>> amt_i);

  always_comb begin
    data_o = data_i << amt_i;
    case (shift_op_e'(op_i))
      ShiftSrl: data_o = data_i >> amt_i;
      ShiftSra: data_o = sra_data;
      ShiftRol: data_o = rol_wide[2*DATA_WIDTH-1:DATA_WIDTH];
      ShiftRor: data_o = ror_wide[DATA_WIDTH-1:0];
      default:  data_o = data_i << amt_i;
    endcase
  end

endmodule

// File: rtl/jedro_1_shift_unit.sv
// Iterative shifter: accepts one request, shifts at most MAX_STEP bits per cycle,
// and holds the result until the consumer takes it.
module jedro_1_shift_unit
  import jedro_1_defines::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_STEP   = 4,
  localparam int unsigned ShWidth   = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  input  logic [ShWidth-1:0]    shamt_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  busy_o
);

  localparam int unsigned AmtWidth = $clog2(MAX_STEP + 1);
  localparam logic [ShWidth:0] MaxStepExt = (ShWidth + 1)'(MAX_STEP);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [ShWidth-1:0]    remaining_q, remaining_d;

  logic [ShWidth:0]      step_ext;
  logic [AmtWidth-1:0]   step_amt;
  logic [DATA_WIDTH-1:0] step_data;
  logic                  accept;

  assign step_ext = ({1'b0, remaining_q} > MaxStepExt) ? MaxStepExt : {1'b0, remaining_q};
  assign step_amt = AmtWidth'(step_ext);

  jedro_1_shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_STEP   (MAX_STEP)
  ) u_step (
    .op_i   (op_q),
    .data_i (result_q),
    .amt_i  (step_amt),
    .data_o (step_data)
  );

  assign in_ready_o  = (state_q == StIdle) && !flush_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign result_o    = result_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    result_d    = result_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d        = op_i;
          result_d    = operand_i;
          remaining_d = shamt_i;
          state_d     = (shamt_i == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        result_d    = step_data;
        remaining_d = remaining_q - ShWidth'(step_ext);
        if (remaining_d == '0) state_d = StDone;
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush drops the in-flight result even if the consumer handshakes this cycle.
    if (flush_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      op_q        <= 3'(ShiftSll);
      result_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      result_q    <= result_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_jedro_1_shift_unit.sv
// Bench for jedro_1_shift_unit: three instances (MAX_STEP 1, 4, 32) checked
// against a bit-level reference shifter.
module tb_jedro_1_shift_unit;
  import jedro_1_defines::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic [2:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        in_valid  [NI];
  logic        out_ready [NI];
  logic        in_ready  [NI];
  logic        out_valid [NI];
  logic        busy      [NI];
  logic [31:0] result    [NI];

  int total = 0;
  int bad   = 0;

  jedro_1_shift_unit #(.DATA_WIDTH(32), .MAX_STEP(1)) u_ms1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid[0]),
    .in_ready_o(in_ready[0]), .op_i(op), .operand_i(operand), .shamt_i(shamt),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .result_o(result[0]),
    .busy_o(busy[0])
  );

  jedro_1_shift_unit #(.DATA_WIDTH(32), .MAX_STEP(4)) u_ms4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid[1]),
    .in_ready_o(in_ready[1]), .op_i(op), .operand_i(operand), .shamt_i(shamt),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .result_o(result[1]),
    .busy_o(busy[1])
  );

  jedro_1_shift_unit #(.DATA_WIDTH(32), .MAX_STEP(32)) u_ms32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid[2]),
    .in_ready_o(in_ready[2]), .op_i(op), .operand_i(operand), .shamt_i(shamt),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .result_o(result[2]),
    .busy_o(busy[2])
  );

  function automatic int ms_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 32;
  endfunction

  // Each result bit is picked from its source position in the operand.
  function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] a,
                                            input int sh);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      case (o)
        3'd1:    r[i] = (i + sh < 32) ? a[i + sh] : 1'b0;
        3'd2:    r[i] = (i + sh < 32) ? a[i + sh] : a[31];
        3'd3:    r[i] = a[(i - sh + 32) % 32];
        3'd4:    r[i] = a[(i + sh) % 32];
        default: r[i] = (i >= sh) ? a[i - sh] : 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input int k, input logic [2:0] o, input logic [31:0] a,
                       input logic [4:0] sh, input int stalls, input bit hold_valid,
                       output logic [31:0] res);
    int          lat;
    int          exp_lat;
    logic [31:0] exp;
    exp     = ref_shift(o, a, int'(sh));
    exp_lat = (int'(sh) + ms_of(k) - 1) / ms_of(k);
    op = o; operand = a; shamt = sh; in_valid[k] = 1'b1;
    check("in_ready_idle", 64'(in_ready[k]), 64'd1);
    @(posedge clk); #1;
    in_valid[k] = hold_valid;
    op = 3'($urandom); operand = $urandom; shamt = 5'($urandom);
    lat = 0;
    while (!out_valid[k] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", 64'(result[k]), 64'(exp));
    res = result[k];
    for (int s = 0; s < stalls; s++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid[k]), 64'd1);
      check("stall_result", 64'(result[k]), 64'(exp));
      if (hold_valid) check("stall_in_ready", 64'(in_ready[k]), 64'd0);
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b0;
    check("post_hs_valid", 64'(out_valid[k]), 64'd0);
    check("post_hs_busy", 64'(busy[k]), 64'd0);
  endtask

  // Starts a 31-bit SRL on instance 1 and aborts it in the second SHIFT cycle.
  task automatic abort_shift(input bit use_reset);
    in_valid[1] = 1'b1; op = 3'd1; operand = 32'hFFFF_FFFF; shamt = 5'd31;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_before", 64'(busy[1]), 64'd1);
    if (use_reset) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    #1;
    check("abort_busy", 64'(busy[1]), 64'd0);
    check("abort_in_ready", 64'(in_ready[1]), 64'd1);
    if (use_reset) check("abort_rst_result", 64'(result[1]), 64'd0);
    for (int c = 0; c < 12; c++) begin
      check("abort_no_valid", 64'(out_valid[1]), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; flush = 1'b0; op = '0; operand = '0; shamt = '0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      check("rst_valid", 64'(out_valid[k]), 64'd0);
      check("rst_busy", 64'(busy[k]), 64'd0);
      check("rst_in_ready", 64'(in_ready[k]), 64'd1);
      check("rst_result", 64'(result[k]), 64'd0);
    end

    // Chained SLL 1 -> 2 -> 8 -> 64 on MAX_STEP=4
    do_op(1, 3'd0, 32'h1, 5'd1, 0, 1'b0, r);
    do_op(1, 3'd0, r, 5'd2, 0, 1'b0, r);
    do_op(1, 3'd0, r, 5'd3, 0, 1'b0, r);
    check("chain_final", 64'(r), 64'd64);

    do_op(1, 3'd2, 32'h8000_0000, 5'd31, 1, 1'b0, r);
    check("sra31", 64'(r), 64'hFFFF_FFFF);
    do_op(1, 3'd1, 32'h8000_0000, 5'd31, 1, 1'b0, r);
    check("srl31", 64'(r), 64'h1);
    do_op(1, 3'd4, 32'h0000_000F, 5'd4, 0, 1'b0, r);
    check("ror4", 64'(r), 64'hF000_0000);
    do_op(1, 3'd3, 32'h8000_0001, 5'd1, 0, 1'b0, r);
    check("rol1", 64'(r), 64'h3);
    do_op(1, 3'd0, 32'hDEAD_BEEF, 5'd0, 0, 1'b0, r);
    check("shamt0", 64'(r), 64'hDEAD_BEEF);
    do_op(1, 3'd7, 32'h0000_00F1, 5'd4, 0, 1'b0, r);
    check("bad_op_sll", 64'(r), 64'h0000_0F10);

    // Backpressure with a pending request, then the next request is accepted
    do_op(1, 3'd2, 32'h9000_0000, 5'd6, 5, 1'b1, r);
    do_op(1, 3'd3, 32'h1234_5678, 5'd8, 0, 1'b0, r);
    check("after_stall", 64'(r), 64'h3456_7812);

    abort_shift(1'b0);
    abort_shift(1'b1);

    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 350; n++) begin
        do_op(k, 3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
